int_ctrl: RTL and testbench

External interrupt controller that drives the `INT0` input of the single-cycle RISC-V core, i.e. the request side of the core's interrupt interface.
- Captures up to `N_SRC` external request lines, applies a software enable mask, and picks the lowest-numbered pending source.
- Holds `INT0` with a stable source ID until the core acknowledges trap entry, then tracks the in-service source until `mret` completes it.
- Exposes a four-word register window on the data bus.

---
 rtl/int_ctrl_if.sv | 24 ++
 rtl/int_ctrl.sv | 138 +++++++++++++
 tb/tb_int_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/int_ctrl_if.sv
// Request/bus bundle between int_ctrl (slave) and the core plus data bus (master).
interface int_ctrl_if #(
  parameter int N_SRC = 8
);
  logic [N_SRC-1:0] irq_in;
  logic             int_ack;
  logic             int_done;
  logic [1:0]       bus_addr;
  logic             bus_we;
  logic [31:0]      bus_wdata;
  logic [31:0]      bus_rdata;
  logic             INT0;
  logic [4:0]       int_id;

  modport master (
    output irq_in, int_ack, int_done, bus_addr, bus_we, bus_wdata,
    input  bus_rdata, INT0, int_id
  );

  modport slave (
    input  irq_in, int_ack, int_done, bus_addr, bus_we, bus_wdata,
    output bus_rdata, INT0, int_id
  );
endinterface

// File: rtl/int_ctrl.sv
// External interrupt controller feeding INT0 of the core; lowest pending enabled source wins.
// Define INT_CTRL_EDGE_EN for edge-triggered capture with W1C; otherwise requests are level-sensitive.
module int_ctrl #(
  parameter int N_SRC = 8
) (
  input logic       clk,
  input logic       rst,
  int_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_e;

  state_e           state_q;
  logic             int0_q;
  logic [4:0]       intId_q;
  logic [N_SRC-1:0] enable_q;
  logic [N_SRC-1:0] pending_q;
  logic [N_SRC-1:0] pending_d;
  logic [N_SRC-1:0] cand;
  logic [4:0]       winner;
  logic [31:0]      candExt;
  logic [31:0]      rdata;
  logic             enWrite;
  logic             unusedWdata;

  assign enWrite     = bus.bus_we && (bus.bus_addr == 2'd0);
  assign unusedWdata = ^bus.bus_wdata[31:N_SRC];

`ifdef INT_CTRL_EDGE_EN
  logic [N_SRC-1:0] irq_q;
  logic [N_SRC-1:0] clearMask;
  logic             pendWrite;
  logic             ackClear;

  assign pendWrite = bus.bus_we && (bus.bus_addr == 2'd1);
  assign ackClear  = (state_q == REQ) && bus.int_ack;

  // A fresh rising edge outranks a W1C or ack-clear landing on the same bit.
  always_comb begin
    clearMask = '0;
    for (int i = 0; i < N_SRC; i++) begin
      clearMask[i] = (ackClear && (intId_q == 5'(i))) || (pendWrite && bus.bus_wdata[i]);
    end
    pending_d = (pending_q & ~clearMask) | (bus.irq_in & ~irq_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_q <= '0;
    end else begin
      irq_q <= bus.irq_in;
    end
  end
`else
  assign pending_d = bus.irq_in;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
      enable_q  <= '0;
    end else begin
      pending_q <= pending_d;
      if (enWrite) begin
        enable_q <= bus.bus_wdata[N_SRC-1:0];
      end
    end
  end

  assign cand = pending_q & enable_q;

  always_comb begin
    winner = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (cand[i]) begin
        winner = 5'(i);
      end
    end
    candExt = '0;
    candExt[N_SRC-1:0] = cand;
  end

  // Acknowledge is tested before retraction so an ack always reaches SERVICE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      int0_q  <= 1'b0;
      intId_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|cand) begin
            intId_q <= winner;
            int0_q  <= 1'b1;
            state_q <= REQ;
          end
        end
        REQ: begin
          if (bus.int_ack) begin
            int0_q  <= 1'b0;
            state_q <= SERVICE;
          end else if (!candExt[intId_q]) begin
            int0_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        SERVICE: begin
          if (bus.int_done) begin
            state_q <= IDLE;
          end
        end
        default: begin
          int0_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    rdata = '0;
    case (bus.bus_addr)
      2'd0: rdata[N_SRC-1:0] = enable_q;
      2'd1: rdata[N_SRC-1:0] = pending_q;
      2'd2: rdata[5:0]       = (state_q == SERVICE) ? (6'(intId_q) + 6'd1) : 6'd0;
      default: rdata[1:0]    = state_q;
    endcase
  end

  assign bus.bus_rdata = rdata;
  assign bus.INT0      = int0_q;
  assign bus.int_id    = intId_q;

endmodule

// File: tb/tb_int_ctrl.sv
// Self-checking bench for int_ctrl; expected request IDs travel through a scoreboard queue.
module tb_int_ctrl;

  logic clk;
  logic rst;
  int   compared;
  int   mismatched;
  int   expQ[$];

  int_ctrl_if #(.N_SRC(8)) ifc ();

  int_ctrl #(.N_SRC(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyWrite(input logic [1:0] addr, input logic [31:0] data);
    ifc.bus_addr  = addr;
    ifc.bus_wdata = data;
    ifc.bus_we    = 1'b1;
    step();
    ifc.bus_we    = 1'b0;
  endtask

  task automatic readReg(input logic [1:0] addr, output logic [31:0] data);
    ifc.bus_addr = addr;
    #1;
    data = ifc.bus_rdata;
  endtask

  task automatic pulseAck();
    ifc.int_ack = 1'b1;
    step();
    ifc.int_ack = 1'b0;
  endtask

  task automatic pulseDone();
    ifc.int_done = 1'b1;
    step();
    ifc.int_done = 1'b0;
  endtask

  // Returns the number of edges until INT0 is seen high, or -1 if it never rises.
  task automatic waitInt0(output int cycles);
    cycles = -1;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (ifc.INT0 === 1'b1) begin
        cycles = i;
        break;
      end
    end
  endtask

  task automatic popId(output int id);
    if (expQ.size() == 0) id = -1;
    else id = expQ.pop_front();
  endtask

  task automatic test_reset();
    logic [31:0] r;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    compared++;
    if (ifc.INT0 !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_int0: got %0b expected 0", ifc.INT0); end
    compared++;
    if (ifc.int_id !== 5'd0) begin mismatched++; $display("[TB] FAIL reset_id: got %0d expected 0", ifc.int_id); end
    readReg(2'd0, r);
    compared++;
    if (r !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_enable: got %0h expected 0", r); end
    readReg(2'd1, r);
    compared++;
    if (r !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_pending: got %0h expected 0", r); end
    readReg(2'd3, r);
    compared++;
    if (r !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_status: got %0h expected 0", r); end
  endtask

  task automatic test_single();
    logic [31:0] r;
    int cyc, id;
    applyWrite(2'd0, 32'h02);
    ifc.irq_in = 8'h02;
    expQ.push_back(1);
    waitInt0(cyc);
    compared++;
    if (cyc !== 2) begin mismatched++; $display("[TB] FAIL single_latency: got %0d expected 2", cyc); end
    popId(id);
    compared++;
    if (int'(ifc.int_id) !== id) begin mismatched++; $display("[TB] FAIL single_id: got %0d expected %0d", ifc.int_id, id); end
    readReg(2'd3, r);
    compared++;
    if (r !== 32'h1) begin mismatched++; $display("[TB] FAIL single_status_req: got %0h expected 1", r); end
    pulseAck();
    compared++;
    if (ifc.INT0 !== 1'b0) begin mismatched++; $display("[TB] FAIL single_ack_int0: got %0b expected 0", ifc.INT0); end
    readReg(2'd2, r);
    compared++;
    if (r !== 32'h2) begin mismatched++; $display("[TB] FAIL single_claim: got %0h expected 2", r); end
    pulseAck();
    readReg(2'd3, r);
    compared++;
    if (r !== 32'h2) begin mismatched++; $display("[TB] FAIL single_stray_ack: got %0h expected 2", r); end
`ifdef INT_CTRL_EDGE_EN
    readReg(2'd1, r);
    compared++;
    if (r !== 32'h0) begin mismatched++; $display("[TB] FAIL single_ack_clear: got %0h expected 0", r); end
    ifc.irq_in = 8'h00;
    pulseDone();
    readReg(2'd2, r);
    compared++;
    if (r !== 32'h0) begin mismatched++; $display("[TB] FAIL single_claim_done: got %0h expected 0", r); end
    step();
    step();
    compared++;
    if (ifc.INT0 !== 1'b0) begin mismatched++; $display("[TB] FAIL single_quiet: got %0b expected 0", ifc.INT0); end
`else
    readReg(2'd1, r);
    compared++;
    if (r !== 32'h2) begin mismatched++; $display("[TB] FAIL level_pending_after_ack: got %0h expected 2", r); end
    applyWrite(2'd1, 32'h02);
    readReg(2'd1, r);
    compared++;
    if (r !== 32'h2) begin mismatched++; $display("[TB] FAIL level_w1c_ignored: got %0h expected 2", r); end
    pulseDone();
    readReg(2'd3, r);
    compared++;
    if (r !== 32'h0) begin mismatched++; $display("[TB] FAIL level_status_done: got %0h expected 0", r); end
    expQ.push_back(1);
    waitInt0(cyc);
    compared++;
    if (cyc !== 1) begin mismatched++; $display("[TB] FAIL level_reraise: got %0d expected 1", cyc); end
    popId(id);
    compared++;
    if (int'(ifc.int_id) !== id) begin mismatched++; $display("[TB] FAIL level_reraise_id: got %0d expected %0d", ifc.int_id, id); end
    ifc.irq_in = 8'h00;
    step();
    step();
    compared++;
    if (ifc.INT0 !== 1'b0) begin mismatched++; $display("[TB] FAIL level_retract: got %0b expected 0", ifc.INT0); end
    readReg(2'd3, r);
    compared++;
    if (r !== 32'h0) begin mismatched++; $display("[TB] FAIL level_retract_state: got %0h expected 0", r); end
`endif
    applyWrite(2'd0, 32'h00);
  endtask

  task automatic test_priority();
    logic [31:0] r;
    int cyc, id;
    applyWrite(2'd0, 32'hFF);
    ifc.irq_in = 8'h24;
    expQ.push_back(2);
    expQ.push_back(5);
    waitInt0(cyc);
    popId(id);
    compared++;
    if (int'(ifc.int_id) !== id) begin mismatched++; $display("[TB] FAIL prio_first: got %0d expected %0d", ifc.int_id, id); end
    pulseDone();
    readReg(2'd3, r);
    compared++;
    if (r !== 32'h1) begin mismatched++; $display("[TB] FAIL prio_stray_done: got %0h expected 1", r); end
    pulseAck();
    ifc.irq_in = 8'h20;
    pulseDone();
    readReg(2'd3, r);
    compared++;
    if (r !== 32'h0) begin mismatched++; $display("[TB] FAIL prio_idle: got %0h expected 0", r); end
    waitInt0(cyc);
    compared++;
    if (cyc !== 1) begin mismatched++; $display("[TB] FAIL prio_second_latency: got %0d expected 1", cyc); end
    popId(id);
    compared++;
    if (int'(ifc.int_id) !== id) begin mismatched++; $display("[TB] FAIL prio_second: got %0d expected %0d", ifc.int_id, id); end
    pulseAck();
    ifc.irq_in = 8'h00;
    pulseDone();
    applyWrite(2'd0, 32'h00);
  endtask

  task automatic test_mask_retract();
    logic [31:0] r;
    int cyc, id;
    ifc.irq_in = 8'h08;
    step();
    readReg(2'd1, r);
    compared++;
    if (r !== 32'h08) begin mismatched++; $display("[TB] FAIL mask_pending: got %0h expected 8", r); end
    step();
    step();
    compared++;
    if (ifc.INT0 !== 1'b0) begin mismatched++; $display("[TB] FAIL mask_blocked: got %0b expected 0", ifc.INT0); end
    applyWrite(2'd0, 32'h08);
    expQ.push_back(3);
    waitInt0(cyc);
    compared++;
    if (cyc !== 1) begin mismatched++; $display("[TB] FAIL mask_enable_latency: got %0d expected 1", cyc); end
    popId(id);
    compared++;
    if (int'(ifc.int_id) !== id) begin mismatched++; $display("[TB] FAIL mask_id: got %0d expected %0d", ifc.int_id, id); end
    applyWrite(2'd0, 32'h00);
    step();
    compared++;
    if (ifc.INT0 !== 1'b0) begin mismatched++; $display("[TB] FAIL retract_int0: got %0b expected 0", ifc.INT0); end
    readReg(2'd3, r);
    compared++;
    if (r !== 32'h0) begin mismatched++; $display("[TB] FAIL retract_state: got %0h expected 0", r); end
    applyWrite(2'd0, 32'h08);
    expQ.push_back(3);
    waitInt0(cyc);
    popId(id);
    compared++;
    if (int'(ifc.int_id) !== id) begin mismatched++; $display("[TB] FAIL rearm_id: got %0d expected %0d", ifc.int_id, id); end
    applyWrite(2'd0, 32'h00);
    pulseAck();
    readReg(2'd3, r);
    compared++;
    if (r !== 32'h2) begin mismatched++; $display("[TB] FAIL ack_beats_retract: got %0h expected 2", r); end
    readReg(2'd2, r);
    compared++;
    if (r !== 32'h4) begin mismatched++; $display("[TB] FAIL ack_beats_claim: got %0h expected 4", r); end
    ifc.irq_in = 8'h00;
    pulseDone();
  endtask

`ifdef INT_CTRL_EDGE_EN
  task automatic test_edge_w1c();
    logic [31:0] r;
    ifc.irq_in = 8'h10;
    applyWrite(2'd1, 32'h10);
    readReg(2'd1, r);
    compared++;
    if (r !== 32'h10) begin mismatched++; $display("[TB] FAIL edge_set_wins: got %0h expected 10", r); end
    applyWrite(2'd1, 32'h10);
    readReg(2'd1, r);
    compared++;
    if (r !== 32'h0) begin mismatched++; $display("[TB] FAIL edge_w1c: got %0h expected 0", r); end
    ifc.irq_in = 8'h00;
    step();
  endtask
`endif

  task automatic test_reset_mid_service();
    logic [31:0] r;
    int cyc, id;
    applyWrite(2'd0, 32'h04);
    ifc.irq_in = 8'h04;
    expQ.push_back(2);
    waitInt0(cyc);
    popId(id);
    compared++;
    if (int'(ifc.int_id) !== id) begin mismatched++; $display("[TB] FAIL midrst_id: got %0d expected %0d", ifc.int_id, id); end
    pulseAck();
    readReg(2'd2, r);
    compared++;
    if (r !== 32'h3) begin mismatched++; $display("[TB] FAIL midrst_claim: got %0h expected 3", r); end
    ifc.irq_in = 8'h00;
    rst = 1'b1;
    step();
    rst = 1'b0;
    compared++;
    if (ifc.int_id !== 5'd0) begin mismatched++; $display("[TB] FAIL midrst_id_cleared: got %0d expected 0", ifc.int_id); end
    readReg(2'd0, r);
    compared++;
    if (r !== 32'h0) begin mismatched++; $display("[TB] FAIL midrst_enable: got %0h expected 0", r); end
    readReg(2'd2, r);
    compared++;
    if (r !== 32'h0) begin mismatched++; $display("[TB] FAIL midrst_claim_cleared: got %0h expected 0", r); end
    pulseDone();
    readReg(2'd3, r);
    compared++;
    if (r !== 32'h0) begin mismatched++; $display("[TB] FAIL midrst_done_ignored: got %0h expected 0", r); end
    compared++;
    if (ifc.INT0 !== 1'b0) begin mismatched++; $display("[TB] FAIL midrst_int0: got %0b expected 0", ifc.INT0); end
  endtask

  initial begin
    compared      = 0;
    mismatched    = 0;
    rst           = 1'b1;
    ifc.irq_in    = '0;
    ifc.int_ack   = 1'b0;
    ifc.int_done  = 1'b0;
    ifc.bus_addr  = 2'd0;
    ifc.bus_we    = 1'b0;
    ifc.bus_wdata = '0;
    test_reset();
    test_single();
    test_priority();
    test_mask_retract();
`ifdef INT_CTRL_EDGE_EN
    test_edge_w1c();
`endif
    test_reset_mid_service();
    compared++;
    if (expQ.size() !== 0) begin mismatched++; $display("[TB] FAIL scoreboard_drain: got %0d left expected 0", expQ.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
